mem_copy_engine: RTL
====================

# mem_copy_engine

The block is a bus-master sequencer that sits directly upstream of main memory on the shared 16-bit-address, 256-bit-data system bus. On a single start pulse it copies `count` consecutive 256-bit words from a source address to a destination address. It drives `address`, `nRead`, `nWrite` and `ExeDataOut` with the same protocol the execute unit uses. It moves matrix operands and results between memory slots without execute-unit involvement.

## Interface
- `ADDR_W`, default 16: bus address width. Bits [15:12] select the unit; bits [7:0] are the word index.
- `DATA_W`, default 256: bus data width, one matrix row-block per word.
- `CNT_W`, default 8: width of the word-count field.
- `Clk`, input, 1: system clock. The engine operates on posedge; memory samples on negedge.
- `nReset`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: one-cycle request pulse. Sampled only in IDLE.
- `src_addr`, input, ADDR_W: first source word address. Latched on start.
- `dst_addr`, input, ADDR_W: first destination word address. Latched on start.
- `count`, input, CNT_W: number of words to copy. Latched on start.
- `MemDataIn`, input, DATA_W: read data returned by memory (its `MemDataOut`).
- `address`, output, ADDR_W: bus address.
- `nRead`, output, 1: active-low read strobe.
- `nWrite`, output, 1: active-low write strobe.
- `ExeDataOut`, output, DATA_W: write data to memory.
- `busy`, output, 1: high from the cycle after an accepted start until done.
- `done`, output, 1: one-cycle completion pulse.
- `error`, output, 1: one-cycle pulse coincident with `done` when the request was rejected or aborted.

## Operation
- Reset values: `address`=0, `nRead`=1, `nWrite`=1, `ExeDataOut`=0, `busy`=0, `done`=0, `error`=0. The FSM goes to IDLE and the word counter clears.
- States and transitions:
  - IDLE → CHK on `start`.
  - CHK → RD if valid.
  - CHK → FIN with error if `count`=0 or a range check fails.
  - RD → CAP → WR.
  - WR → RD if more words remain, otherwise FIN.
  - FIN → IDLE.
- Range check in CHK:
  - `src_addr[7:0] + count > 256` fails.
  - `dst_addr[7:0] + count > 256` fails.
  - `count = 0` gives `done` without `error` and no bus activity.
- RD: drive `address`=src pointer, `nRead`=0.
- CAP: `nRead`=1; capture `MemDataIn` into the 256-bit holding buffer.
- WR: drive `address`=dst pointer, `nWrite`=0, `ExeDataOut`=buffer. Then increment the low 8 bits of both pointers. Bits [15:8] never change.
- `nRead` and `nWrite` are never low in the same cycle. Outside RD and WR both strobes are high.
- `ExeDataOut` holds its last written value when idle.
- `start` while `busy` is ignored, with no queueing.
- Overlapping source and destination ranges are copied in ascending order, with no hazard protection. Software handles overlap.
- Reset mid-operation aborts immediately. Partially written destination words stay written, and no `done` is issued.

## Timing
- All outputs are registered on posedge Clk.
- In RD, memory samples the strobe at the following negedge. Read data is valid on `MemDataIn` at the next posedge and is captured in CAP.
- Per-word cost is 3 cycles (RD, CAP, WR).
- Latency from the `start` cycle to the `done` pulse is 2 + 3·count cycles. For rejected or zero-count requests it is 2 cycles.
- `busy` is high in CHK through FIN inclusive. `busy` drops in the cycle after `done`.

## Configuration
- Macro: `MEM_COPY_VERIFY_EN`.
- Defined:
  - After each WR, add state VRD: `address`=dst, `nRead`=0.
  - Then add state VCMP, which compares `MemDataIn` to the buffer.
  - A mismatch goes to FIN with `error`. Remaining words are skipped.
  - Per-word cost becomes 5 cycles, so latency is 2 + 5·count.
- Undefined: no readback, and the states are not synthesized.

## Test plan
- Preload mem[0]=A, mem[1]=B. Start src=0x0000, dst=0x0004, count=2 → mem[4]=A, mem[5]=B, `done` at cycle 8 after start, `error`=0, strobes never both low.
- Start with count=0 → `done` at cycle 2, `error`=0, `nRead` and `nWrite` stay 1 throughout.
- Start src=0x00FF, count=2 → `done` and `error` at cycle 2, no bus strobes.
- Start src=0x0000, dst=0x0008, count=3, then pulse `start` again 2 cycles later → only one copy occurs and exactly one `done`.
- Assert `nReset` in the WR of word 2 of 4 → all outputs return to reset values immediately, no `done`, only words 0 and 1 are written at the destination.
- With `MEM_COPY_VERIFY_EN` and a memory model that ignores writes to 0x0005: copy src=0, dst=4, count=3 → `error` and `done` after word 1 at cycle 12, and mem[6] is untouched.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus-master sequencer copying count words src -> dst.
// Define MEM_COPY_VERIFY_EN to add a readback compare after each write.
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 256,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] MemDataIn,
  output logic [ADDR_W-1:0] address,
  output logic              nRead,
  output logic              nWrite,
  output logic [DATA_W-1:0] ExeDataOut,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int EW = ((CNT_W > 8) ? CNT_W : 8) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_RD,
    S_CAP,
    S_WR,
`ifdef MEM_COPY_VERIFY_EN
    S_VRD,
    S_VCMP,
`endif
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_nx;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_idx_nx;
  logic [CNT_W-1:0]  w_idx_inc;
  logic [DATA_W-1:0] r_buf;
  logic [EW-1:0]     w_src_end;
  logic [EW-1:0]     w_dst_end;
  logic [7:0]        w_off;
  logic [ADDR_W-1:0] w_src_a;
  logic [ADDR_W-1:0] w_dst_a;
  logic              w_err;
  logic              w_bad;
  logic              w_last;
  logic              w_rd_nx;
  logic              w_dst_sel;

  assign w_src_end = EW'(r_src[7:0]) + EW'(r_cnt);
  assign w_dst_end = EW'(r_dst[7:0]) + EW'(r_cnt);
  assign w_bad     = (w_src_end > EW'(256)) || (w_dst_end > EW'(256));
  assign w_idx_inc = r_idx + CNT_W'(1);
  assign w_last    = (w_idx_inc == r_cnt);

  // Addresses use the word index of the state being entered.
  assign w_off   = 8'(w_idx_nx);
  assign w_src_a = {r_src[ADDR_W-1:8], r_src[7:0] + w_off};
  assign w_dst_a = {r_dst[ADDR_W-1:8], r_dst[7:0] + w_off};

`ifdef MEM_COPY_VERIFY_EN
  assign w_rd_nx   = (w_nx == S_RD) || (w_nx == S_VRD);
  assign w_dst_sel = (w_nx == S_WR) || (w_nx == S_VRD);
`else
  assign w_rd_nx   = (w_nx == S_RD);
  assign w_dst_sel = (w_nx == S_WR);
`endif

  always_comb begin
    w_nx     = r_state;
    w_err    = 1'b0;
    w_idx_nx = r_idx;
    unique case (r_state)
      S_IDLE: begin
        w_idx_nx = '0;
        if (start) w_nx = S_CHK;
      end
      S_CHK: begin
        if (r_cnt == '0) begin
          w_nx = S_FIN;
        end else if (w_bad) begin
          w_nx  = S_FIN;
          w_err = 1'b1;
        end else begin
          w_nx = S_RD;
        end
      end
      S_RD:  w_nx = S_CAP;
      S_CAP: w_nx = S_WR;
`ifdef MEM_COPY_VERIFY_EN
      S_WR:  w_nx = S_VRD;
      S_VRD: w_nx = S_VCMP;
      S_VCMP: begin
        if (MemDataIn != r_buf) begin
          w_nx  = S_FIN;
          w_err = 1'b1;
        end else begin
          w_idx_nx = w_idx_inc;
          w_nx     = w_last ? S_FIN : S_RD;
        end
      end
`else
      S_WR: begin
        w_idx_nx = w_idx_inc;
        w_nx     = w_last ? S_FIN : S_RD;
      end
`endif
      S_FIN:   w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
      address <= '0;
      nRead   <= 1'b1;
      nWrite  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      r_state <= w_nx;
      r_idx   <= w_idx_nx;
      if (r_state == S_IDLE && start) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_cnt <= count;
      end
      if (r_state == S_CAP) r_buf <= MemDataIn;
      busy   <= (w_nx != S_IDLE);
      done   <= (w_nx == S_FIN);
      error  <= w_err;
      nRead  <= !w_rd_nx;
      nWrite <= (w_nx != S_WR);
      if (w_nx == S_RD) address <= w_src_a;
      else if (w_dst_sel) address <= w_dst_a;
    end
  end

  assign ExeDataOut = r_buf;

endmodule
